// File: rtl/alu_pkg.sv
// Shared encodings and constants for the ALU sequencing controller.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_ADC = 3'b001,
        OP_SUB = 3'b010,
        OP_SBB = 3'b011,
        OP_CMP = 3'b100,
        OP_INC = 3'b101,
        OP_DEC = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_MUL_IT = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam int unsigned MUL_ITERS = 8;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_ITERS);

    // Ops built as A + ~B + 1 report the inverted adder carry as a borrow.
    function automatic logic is_borrow_op(input op_e op);
        return op inside {OP_SUB, OP_SBB, OP_CMP, OP_DEC};
    endfunction

endpackage

// File: rtl/mul_shift_reg.sv
// Shift-add multiply state: partial product P, multiplier Q, multiplicand M and
// the iteration counter. Drives its adder operands and exposes the next P/Q.
module mul_shift_reg
    import alu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_add_z,
    input  logic       i_add_cout,
    output logic [7:0] o_x,
    output logic [7:0] o_y,
    output logic [7:0] o_p_next,
    output logic [7:0] o_q_next,
    output logic       o_last
);

    logic [7:0]           r_p;
    logic [7:0]           r_q;
    logic [7:0]           r_m;
    logic [MUL_CNT_W-1:0] r_cnt;

    logic [7:0] w_p_next;
    logic [7:0] w_q_next;

    // {carry, sum, Q} >> 1: the adder carry lands directly in P[7], so no
    // separate carry register survives past the shift.
    assign w_p_next = {i_add_cout, i_add_z[7:1]};
    assign w_q_next = {i_add_z[0], r_q[7:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p   <= 8'h00;
            r_q   <= 8'h00;
            r_m   <= 8'h00;
            r_cnt <= '0;
        end else if (i_load) begin
            r_p   <= 8'h00;
            r_q   <= i_b;
            r_m   <= i_a;
            r_cnt <= '0;
        end else if (i_step) begin
            r_p   <= w_p_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_x      = r_p;
    assign o_y      = r_q[0] ? r_m : 8'h00;
    assign o_p_next = w_p_next;
    assign o_q_next = w_q_next;
    assign o_last   = (r_cnt == MUL_CNT_W'(MUL_ITERS - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for the shared 8-bit adder: single-cycle arithmetic ops, flag
// generation and an 8-iteration shift-add unsigned multiply.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter bit MUL_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    input  logic        i_cin,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_result,
    output logic        o_flag_c,
    output logic        o_flag_ac,
    output logic        o_flag_z,
    output logic        o_flag_s,
    output logic [7:0]  o_add_x,
    output logic [7:0]  o_add_y,
    output logic        o_add_cin,
    output logic        o_add_xinv,
    output logic        o_add_yinv,
    input  logic [7:0]  i_add_z,
    input  logic        i_add_cout,
    input  logic        i_add_acout
);

    state_e      r_state;
    state_e      w_state_next;
    op_e         r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_cin;
    logic [15:0] r_result;
    logic        r_flag_c;
    logic        r_flag_ac;
    logic        r_flag_z;
    logic        r_flag_s;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_mul_load;
    logic        w_mul_step;
    logic        w_mul_last;
    logic [7:0]  w_mul_x;
    logic [7:0]  w_mul_y;
    logic [7:0]  w_mul_p_next;
    logic [7:0]  w_mul_q_next;
    logic [15:0] w_mul_result;
    logic        w_borrow;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_is_mul     = MUL_EN && (i_op == OP_MUL);
    assign w_mul_load   = w_accept && w_is_mul;
    assign w_mul_step   = (r_state == S_MUL_IT);
    assign w_mul_result = {w_mul_p_next, w_mul_q_next};
    assign w_borrow     = is_borrow_op(r_op);

    mul_shift_reg u_mul (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_mul_load),
        .i_step     (w_mul_step),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_add_z    (i_add_z),
        .i_add_cout (i_add_cout),
        .o_x        (w_mul_x),
        .o_y        (w_mul_y),
        .o_p_next   (w_mul_p_next),
        .o_q_next   (w_mul_q_next),
        .o_last     (w_mul_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = w_is_mul ? S_MUL_IT : S_EXEC;
                end
            end
            S_EXEC: w_state_next = S_DONE;
            S_MUL_IT: begin
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Adder operands are forced to zero outside EXEC/MUL_IT so it idles at a known value.
    always_comb begin
        o_add_x   = 8'h00;
        o_add_y   = 8'h00;
        o_add_cin = 1'b0;
        if (r_state == S_EXEC) begin
            case (r_op)
                OP_ADD: begin
                    o_add_x = r_a;
                    o_add_y = r_b;
                end
                OP_ADC: begin
                    o_add_x   = r_a;
                    o_add_y   = r_b;
                    o_add_cin = r_cin;
                end
                OP_SUB, OP_CMP: begin
                    o_add_x   = r_a;
                    o_add_y   = ~r_b;
                    o_add_cin = 1'b1;
                end
                OP_SBB: begin
                    o_add_x   = r_a;
                    o_add_y   = ~r_b;
                    o_add_cin = ~r_cin;
                end
                OP_INC: begin
                    o_add_x   = r_a;
                    o_add_cin = 1'b1;
                end
                OP_DEC: begin
                    o_add_x = r_a;
                    o_add_y = 8'hFF;
                end
                default: begin
                    o_add_x = 8'h00;
                end
            endcase
        end else if (r_state == S_MUL_IT) begin
            o_add_x = w_mul_x;
            o_add_y = w_mul_y;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op      <= OP_ADD;
            r_a       <= 8'h00;
            r_b       <= 8'h00;
            r_cin     <= 1'b0;
            r_result  <= 16'h0000;
            r_flag_c  <= 1'b0;
            r_flag_ac <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_s  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_e'(i_op);
                r_a   <= i_a;
                r_b   <= i_b;
                r_cin <= i_cin;
            end
            if (r_state == S_EXEC) begin
                if (r_op == OP_MUL) begin
                    // Only reachable with MUL disabled: a no-op that clears everything.
                    r_result  <= 16'h0000;
                    r_flag_c  <= 1'b0;
                    r_flag_ac <= 1'b0;
                    r_flag_z  <= 1'b0;
                    r_flag_s  <= 1'b0;
                end else begin
                    r_flag_c  <= i_add_cout ^ w_borrow;
                    r_flag_ac <= i_add_acout ^ w_borrow;
                    r_flag_z  <= (i_add_z == 8'h00);
                    r_flag_s  <= i_add_z[7];
                    if (r_op != OP_CMP) begin
                        r_result <= {8'h00, i_add_z};
                    end
                end
            end
            if ((r_state == S_MUL_IT) && w_mul_last) begin
                r_result  <= w_mul_result;
                r_flag_c  <= (w_mul_p_next != 8'h00);
                r_flag_ac <= 1'b0;
                r_flag_z  <= (w_mul_result == 16'h0000);
                r_flag_s  <= w_mul_result[15];
            end
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_result   = r_result;
    assign o_flag_c   = r_flag_c;
    assign o_flag_ac  = r_flag_ac;
    assign o_flag_z   = r_flag_z;
    assign o_flag_s   = r_flag_s;
    assign o_add_xinv = 1'b0;
    assign o_add_yinv = 1'b0;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural adder, arithmetic reference model with
// per-cycle compare, directed literal cases and randomized command traffic.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        flag_c;
    logic        flag_ac;
    logic        flag_z;
    logic        flag_s;
    logic [7:0]  add_x;
    logic [7:0]  add_y;
    logic        add_cin;
    logic        add_xinv;
    logic        add_yinv;
    logic [7:0]  add_z;
    logic        add_cout;
    logic        add_acout;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(
        .MUL_EN (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_op        (op),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_flag_c    (flag_c),
        .o_flag_ac   (flag_ac),
        .o_flag_z    (flag_z),
        .o_flag_s    (flag_s),
        .o_add_x     (add_x),
        .o_add_y     (add_y),
        .o_add_cin   (add_cin),
        .o_add_xinv  (add_xinv),
        .o_add_yinv  (add_yinv),
        .i_add_z     (add_z),
        .i_add_cout  (add_cout),
        .i_add_acout (add_acout)
    );

    // Behavioural ripple adder.
    logic [7:0] x_eff;
    logic [7:0] y_eff;
    logic [8:0] full_sum;
    logic [4:0] nib_sum;
    assign x_eff     = add_xinv ? ~add_x : add_x;
    assign y_eff     = add_yinv ? ~add_y : add_y;
    assign full_sum  = 9'(x_eff) + 9'(y_eff) + 9'(add_cin);
    assign nib_sum   = 5'(x_eff[3:0]) + 5'(y_eff[3:0]) + 5'(add_cin);
    assign add_z     = full_sum[7:0];
    assign add_cout  = full_sum[8];
    assign add_acout = nib_sum[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: flags from integer comparisons, not adder bits.
    function automatic void ref_cmd(input logic [2:0] f_op, input logic [7:0] f_a,
                                    input logic [7:0] f_b, input logic f_cin,
                                    input logic [15:0] prev, output logic [15:0] res,
                                    output logic c, output logic ac, output logic z,
                                    output logic s);
        int ia, ib, ic, alo, blo, r;
        ia = int'(f_a); ib = int'(f_b); ic = int'(f_cin);
        alo = ia % 16; blo = ib % 16;
        r = 0; c = 1'b0; ac = 1'b0;
        case (f_op)
            3'd0: begin r = ia + ib;      c = (r > 255);       ac = (alo + blo > 15);      end
            3'd1: begin r = ia + ib + ic; c = (r > 255);       ac = (alo + blo + ic > 15); end
            3'd2, 3'd4: begin r = ia - ib; c = (ia < ib);      ac = (alo < blo);           end
            3'd3: begin r = ia - ib - ic; c = (ia < ib + ic);  ac = (alo < blo + ic);      end
            3'd5: begin r = ia + 1;       c = (ia == 255);     ac = (alo == 15);           end
            3'd6: begin r = ia - 1;       c = (ia == 0);       ac = (alo == 0);            end
            default: r = ia * ib;
        endcase
        if (f_op == 3'd7) begin
            res = r[15:0];
            c   = (r > 255);
            ac  = 1'b0;
            z   = (r == 0);
            s   = res[15];
        end else begin
            z   = (r[7:0] == 8'h00);
            s   = r[7];
            res = (f_op == 3'd4) ? prev : {8'h00, r[7:0]};
        end
    endfunction

    // Expected {cin, y} the adder sees during a single-op execute cycle.
    function automatic logic [8:0] exec_ops(input logic [2:0] f_op, input logic [7:0] f_b,
                                            input logic f_cin);
        case (f_op)
            3'd0:       return {1'b0, f_b};
            3'd1:       return {f_cin, f_b};
            3'd2, 3'd4: return {1'b1, ~f_b};
            3'd3:       return {~f_cin, ~f_b};
            3'd5:       return {1'b1, 8'h00};
            3'd6:       return {1'b0, 8'hFF};
            default:    return 9'h000;
        endcase
    endfunction

    // Model: m_phase counts cycles since acceptance (0 = idle), m_len = done cycle.
    int          m_phase = 0;
    int          m_len   = 0;
    logic [2:0]  m_op    = 3'd0;
    logic [7:0]  m_a     = 8'h00;
    logic [7:0]  m_b     = 8'h00;
    logic        m_cin   = 1'b0;
    logic [15:0] m_res   = 16'h0000;
    logic        m_c = 1'b0, m_ac = 1'b0, m_z = 1'b0, m_s = 1'b0;
    logic [15:0] p_res   = 16'h0000;
    logic        p_c = 1'b0, p_ac = 1'b0, p_z = 1'b0, p_s = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] t_res;
        logic        t_c, t_ac, t_z, t_s;
        if (!rst_n) begin
            m_phase <= 0;
            m_len   <= 0;
            m_res   <= 16'h0000;
            m_c <= 1'b0; m_ac <= 1'b0; m_z <= 1'b0; m_s <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                ref_cmd(op, a, b, cin, m_res, t_res, t_c, t_ac, t_z, t_s);
                p_res <= t_res;
                p_c <= t_c; p_ac <= t_ac; p_z <= t_z; p_s <= t_s;
                m_op <= op; m_a <= a; m_b <= b; m_cin <= cin;
                m_len   <= (op == 3'd7) ? 9 : 2;
                m_phase <= 1;
            end
        end else begin
            if (m_phase == m_len - 1) begin
                m_res <= p_res;
                m_c <= p_c; m_ac <= p_ac; m_z <= p_z; m_s <= p_s;
            end
            m_phase <= (m_phase == m_len) ? 0 : m_phase + 1;
        end
    end

    always @(negedge clk) begin
        logic [8:0] t_ops;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'((m_phase != 0) && (m_phase == m_len)));
            chk("result", 32'(result), 32'(m_res));
            chk("flags", 32'({flag_c, flag_ac, flag_z, flag_s}), 32'({m_c, m_ac, m_z, m_s}));
            chk("inv", 32'({add_xinv, add_yinv}), 32'd0);
            if (m_phase == 1 && m_len == 2) begin
                t_ops = exec_ops(m_op, m_b, m_cin);
                chk("exec_x", 32'(add_x), 32'(m_a));
                chk("exec_y", 32'(add_y), 32'(t_ops[7:0]));
                chk("exec_cin", 32'(add_cin), 32'(t_ops[8]));
            end else if (m_len == 9 && m_phase >= 1 && m_phase <= 8) begin
                chk("mul_y", 32'((add_y == 8'h00) || (add_y == m_a)), 32'd1);
                chk("mul_cin", 32'(add_cin), 32'd0);
            end else begin
                chk("idle_ops", 32'({add_x, add_y, add_cin}), 32'd0);
            end
        end
    end

    task automatic run_cmd(input logic [2:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                           input logic t_cin, input int dup_at, output int lat,
                           output int n_done, output logic [7:0] ex_y, output logic ex_cin);
        lat = -1; n_done = 0; ex_y = 8'h00; ex_cin = 1'b0;
        @(posedge clk); #2;
        start = 1'b1; op = t_op; a = t_a; b = t_b; cin = t_cin;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #2;
            start = (cyc == dup_at);
            if (cyc == dup_at) begin
                op = 3'd0; a = 8'h01; b = 8'h01;
            end
            if (cyc == 1) begin
                ex_y = add_y; ex_cin = add_cin;
            end
            if (done) begin
                n_done++;
                if (lat < 0) lat = cyc;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, nd;
        logic [7:0] ey;
        logic       ec;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", 32'({busy, done, flag_c, flag_ac, flag_z, flag_s}), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        rst_n = 1'b1;

        run_cmd(3'd0, 8'h3A, 8'hC6, 1'b0, -1, lat, nd, ey, ec);
        chk("add_lat", 32'(lat), 32'd2);
        chk("add_res", 32'(result), 32'h0000);
        chk("add_flags", 32'({flag_c, flag_ac, flag_z, flag_s}), 32'b1110);

        run_cmd(3'd2, 8'h10, 8'h01, 1'b0, -1, lat, nd, ey, ec);
        chk("sub_res", 32'(result), 32'h000F);
        chk("sub_flags", 32'({flag_c, flag_ac, flag_z, flag_s}), 32'b0100);
        chk("sub_ops", 32'({ec, ey}), 32'h1FE);

        run_cmd(3'd3, 8'h05, 8'h05, 1'b1, -1, lat, nd, ey, ec);
        chk("sbb_res", 32'(result), 32'h00FF);
        chk("sbb_czs", 32'({flag_c, flag_z, flag_s}), 32'b101);

        run_cmd(3'd4, 8'h05, 8'h05, 1'b0, -1, lat, nd, ey, ec);
        chk("cmp_res", 32'(result), 32'h00FF);
        chk("cmp_cz", 32'({flag_c, flag_z}), 32'b01);

        run_cmd(3'd7, 8'hFF, 8'hFF, 1'b0, -1, lat, nd, ey, ec);
        chk("mul_lat", 32'(lat), 32'd9);
        chk("mul_res", 32'(result), 32'hFE01);
        chk("mul_flags", 32'({flag_c, flag_z, flag_s}), 32'b101);

        run_cmd(3'd7, 8'h00, 8'h37, 1'b0, -1, lat, nd, ey, ec);
        chk("mul0_res", 32'(result), 32'h0000);
        chk("mul0_z", 32'(flag_z), 32'd1);

        run_cmd(3'd7, 8'h0D, 8'h0B, 1'b0, 3, lat, nd, ey, ec);
        chk("dup_ndone", 32'(nd), 32'd1);
        chk("dup_lat", 32'(lat), 32'd9);
        chk("dup_res", 32'(result), 32'h008F);

        // MUL abandoned by reset at cycle 5
        @(posedge clk); #2;
        start = 1'b1; op = 3'd7; a = 8'hFF; b = 8'hFF;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #2;
            start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_ac, flag_z, flag_s}), 32'd0);
        chk("rst_ops", 32'({add_x, add_y, add_cin}), 32'd0);
        nd = 0;
        repeat (2) begin
            @(posedge clk); #2;
            if (done) nd++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #2;
            if (done) nd++;
        end
        chk("rst_no_done", 32'(nd), 32'd0);
        run_cmd(3'd0, 8'h12, 8'h34, 1'b0, -1, lat, nd, ey, ec);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_res", 32'(result), 32'h0046);

        // Random traffic; starts while busy exercise the ignore path.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(3) == 0);
            op    = 3'($urandom_range(7));
            a     = 8'($urandom);
            b     = 8'($urandom);
            cin   = 1'($urandom_range(1));
        end
        @(posedge clk); #2;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
